counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Sequencer and 2-way round-robin arbiter for the shared ripple counter. Two requesters each ask for a timed interval of N counter ticks. The block grants one at a time, then drives the counter's clear and inhibit inputs to run it from zero to the granted requester's target. It reports completion with a one-cycle done pulse and sits directly between the requesters and the counter's `clockinh`/clear controls.

## Interface
Parameters:
- `SIZE`, default 8: counter size parameter.
- Derived `CW = SIZE+2`: count width, matching the counter output.

Ports:
- `clock`  in  1  single system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  2  level requests; bit i = requester i
- `target0`  in  CW  tick count for requester 0; sampled at grant
- `target1`  in  CW  tick count for requester 1; sampled at grant
- `grant`  out  2  one-hot grant, or 0 when idle
- `busy`  out  1  high in any state other than IDLE
- `done`  out  2  one-cycle pulse on the granted bit at interval completion
- `err`  out  1  one-cycle pulse when `cnt_carry` is seen in RUN
- `cnt_clr`  out  1  drives the counter clear (synchronous to the counter)
- `cnt_inh`  out  1  drives the counter `clockinh`; 1 = hold
- `cnt_value`  in  CW  counter output
- `cnt_carry`  in  1  counter carry out

## Operation
- Reset values (applied immediately on assertion, mid-operation included):
  - `grant`=0, `busy`=0, `done`=0, `err`=0, `cnt_clr`=0, `cnt_inh`=1
  - state IDLE; round-robin pointer favours requester 0
- States and transitions:
  - IDLE: if any `req` is high, pick the winner and latch its target, then go to CLEAR.
  - CLEAR: `cnt_clr`=1, `cnt_inh`=1, grant held. Always go to RUN.
  - RUN: `cnt_inh` = (`cnt_value` == latched target), combinational, so the counter freezes exactly at target.
    - Compare true: go to DONE.
    - `req[g]` dropped: abort and go to IDLE. No done pulse; `cnt_inh` returns to 1.
    - `cnt_carry`=1: pulse `err`, go to IDLE, no done pulse.
    - Abort has priority over carry, and carry has priority over the match.
  - DONE: `done[g]`=1, `cnt_inh`=1, grant held. Always go to IDLE; `grant` clears on entry to IDLE.
- Arbitration:
  - With both requests high in IDLE, the winner is the requester not granted last.
  - The pointer updates only on entry to DONE; an aborted or erred grant does not rotate it.
- Width rules:
  - The target is compared unsigned at full CW.
  - Target 0 completes with no counter increment.
  - Target 2^CW-1 is legal.
- Requesters hold `req` until they see `done`. A `req` still high in the IDLE cycle after DONE is treated as a new request.

## Timing
- `grant` and `busy` rise on the edge after `req` is sampled in IDLE, which is the CLEAR cycle.
- The counter reads 0 in the first RUN cycle and reads k after k RUN edges.
- The `done` pulse occurs exactly target+2 cycles after `grant` rises.
- `grant` falls one cycle after `done`.
- Back-to-back intervals are separated by exactly one IDLE cycle.
- Abort: `grant` falls on the edge after `req[g]` is seen low in RUN.

## Structure
- Shared package `counter_ctrl_pkg` holds:
  - state enum (IDLE, CLEAR, RUN, DONE)
  - `CW` derivation helper
  - requester index constants
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with a registered last-winner pointer and an update enable.
- The FSM, target latch and compare stay in the top level.

## Test plan
- Reset low mid-RUN (target 5 at count 3):
  - All outputs immediately hold reset values.
  - After release, `req`=01 restarts from CLEAR.
- `req`=01, target0=4: CLEAR cycle with `cnt_clr`=1; counter 0..4; `cnt_inh` high while count=4; `done`=01 exactly 6 cycles after `grant`; counter holds 4.
- `req`=11 held, target0=2, target1=3: grant order 01 then 10 then 01. One IDLE cycle between intervals; `done` pulses on the matching bit.
- target1=0 with `req`=10: CLEAR, one RUN cycle with `cnt_inh`=1, then `done`=10 2 cycles after `grant`.
- `req`=01 target0=10, drop `req` at count 3: no `done`, `grant`=0 next edge, `cnt_inh`=1, pointer unchanged (next `req`=11 grants 01).
- Force `cnt_carry`=1 in RUN at count 2: `err` pulses once, no `done`, return to IDLE.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared definitions for the counter sequencer/arbiter slice:
//   - state_t   : sequencer states
//   - cw_of()   : count width derived from the counter SIZE parameter
//   - REQ0/REQ1 : requester index constants
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  // Ripple counter output is two bits wider than its SIZE parameter.
  function automatic int cw_of(input int size);
    return size + 2;
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a registered last-winner pointer.
// Ports:
//   clock    in  1  system clock
//   reset    in  1  asynchronous active-low reset
//   req      in  2  request vector
//   upd_en   in  1  load the pointer with upd_idx
//   upd_idx  in  1  index of the requester that just completed
//   win      out 2  one-hot winner for the current req (combinational)
module rr_arb2
  import counter_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_idx,
  output logic [1:0] win
);

  // Index of the last completed winner; reset to 1 so requester 0 wins a tie.
  logic last_r;

  // Pointer register: moves only when the owner asks for it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (upd_en) begin
      last_r <= upd_idx;
    end else begin
      last_r <= last_r;
    end
  end

  // Winner select: a tie goes to the requester that did not win last.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_r ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter
// Sequencer and 2-way round-robin arbiter in front of the shared ripple
// counter. A granted requester's target is latched, the counter is cleared,
// then released until it reaches the target, and a done pulse is issued.
// Ports:
//   clock      in  1   system clock
//   reset      in  1   asynchronous active-low reset
//   req        in  2   level requests
//   target0/1  in  CW  tick counts, sampled at grant
//   grant      out 2   one-hot grant (0 when idle)
//   busy       out 1   high outside IDLE
//   done       out 2   one-cycle completion pulse on the granted bit
//   err        out 1   one-cycle pulse on counter carry during RUN
//   cnt_clr    out 1   counter synchronous clear
//   cnt_inh    out 1   counter clockinh (1 = hold)
//   cnt_value  in  CW  counter output
//   cnt_carry  in  1   counter carry out
module counter_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter  int SIZE = 8,
  localparam int CW   = cw_of(SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [CW-1:0] target0,
  input  logic [CW-1:0] target1,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [1:0]    done,
  output logic          err,
  output logic          cnt_clr,
  output logic          cnt_inh,
  input  logic [CW-1:0] cnt_value,
  input  logic          cnt_carry
);

  state_t        state_r;
  logic [1:0]    grant_r;
  logic [1:0]    done_r;
  logic          err_r;
  logic          clr_r;
  logic          busy_r;
  logic [CW-1:0] target_r;

  logic [1:0]    win_s;
  logic          match_s;
  logic          abort_s;
  logic          upd_s;

  // Compare, abort detect and pointer-update decode for the RUN state.
  always_comb begin
    match_s = (cnt_value == target_r);
    abort_s = ((req & grant_r) == 2'b00);
    upd_s   = (state_r == RUN) && !abort_s && !cnt_carry && match_s;
  end

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .upd_en  (upd_s),
    .upd_idx (grant_r[REQ1]),
    .win     (win_s)
  );

  // Main sequencer with registered grant/busy/done/err/clear outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      grant_r  <= 2'b00;
      done_r   <= 2'b00;
      err_r    <= 1'b0;
      clr_r    <= 1'b0;
      busy_r   <= 1'b0;
      target_r <= '0;
    end else begin
      done_r <= 2'b00;
      err_r  <= 1'b0;
      clr_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            grant_r  <= win_s;
            target_r <= win_s[REQ1] ? target1 : target0;
            clr_r    <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= CLEAR;
          end else begin
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
          end
        end
        CLEAR: begin
          state_r <= RUN;
        end
        RUN: begin
          // Abort beats carry, carry beats the target match.
          if (abort_s) begin
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_carry) begin
            err_r   <= 1'b1;
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (match_s) begin
            done_r  <= grant_r;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          grant_r <= 2'b00;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          grant_r <= 2'b00;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Inhibit follows the compare in RUN so the counter freezes on the target
  // edge itself; every other state holds the counter.
  always_comb begin
    if (state_r == RUN) begin
      cnt_inh = match_s;
    end else begin
      cnt_inh = 1'b1;
    end
  end

  assign grant   = grant_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign cnt_clr = clr_r;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural ripple counter model.
module tb_counter_arbiter;

  localparam int SIZE = 8;
  localparam int CW   = SIZE + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [CW-1:0] target0 = '0;
  logic [CW-1:0] target1 = '0;
  logic [1:0]    grant;
  logic          busy;
  logic [1:0]    done;
  logic          err;
  logic          cnt_clr;
  logic          cnt_inh;
  logic [CW-1:0] cnt = '0;
  logic          cnt_carry;
  logic          carry_force = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  counter_arbiter #(.SIZE(SIZE)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .target0   (target0),
    .target1   (target1),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cnt_clr   (cnt_clr),
    .cnt_inh   (cnt_inh),
    .cnt_value (cnt),
    .cnt_carry (cnt_carry)
  );

  // Counter model: synchronous clear, count when not inhibited.
  always @(posedge clock) begin
    if (cnt_clr) cnt <= '0;
    else if (!cnt_inh) cnt <= cnt + 1'b1;
  end

  assign cnt_carry = carry_force | (!cnt_inh && (&cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_clr"}, 32'(cnt_clr), 32'd0);
    chk({tag, "_inh"}, 32'(cnt_inh), 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk_reset_vals("rst");
    step(1);
    reset = 1'b1;
    step(1);

    // Both requesting: grant order 01, 10, 01
    req = 2'b11; target0 = 10'd2; target1 = 10'd3;
    step(1);
    chk("rr1_grant", 32'(grant), 32'h1);
    chk("rr1_busy", 32'(busy), 32'd1);
    chk("rr1_clr", 32'(cnt_clr), 32'd1);
    step(1);
    chk("rr1_cnt0", 32'(cnt), 32'd0);
    step(2);
    chk("rr1_cnt2", 32'(cnt), 32'd2);
    chk("rr1_inh", 32'(cnt_inh), 32'd1);
    step(1);
    chk("rr1_done", 32'(done), 32'h1);
    step(1);
    chk("rr_idle_grant", 32'(grant), 32'd0);
    chk("rr_idle_busy", 32'(busy), 32'd0);
    chk("rr_idle_done", 32'(done), 32'd0);
    step(1);
    chk("rr2_grant", 32'(grant), 32'h2);
    step(5);
    chk("rr2_done", 32'(done), 32'h2);
    step(1);
    chk("rr2_idle_grant", 32'(grant), 32'd0);
    step(1);
    chk("rr3_grant", 32'(grant), 32'h1);
    step(4);
    chk("rr3_done", 32'(done), 32'h1);
    req = 2'b00;
    step(1);
    chk("rr3_idle_busy", 32'(busy), 32'd0);

    // Single requester 0, target 4
    req = 2'b01; target0 = 10'd4;
    step(1);
    chk("t4_grant", 32'(grant), 32'h1);
    chk("t4_clr", 32'(cnt_clr), 32'd1);
    chk("t4_inh_clear", 32'(cnt_inh), 32'd1);
    step(1);
    chk("t4_cnt0", 32'(cnt), 32'd0);
    chk("t4_inh_run", 32'(cnt_inh), 32'd0);
    chk("t4_clr_run", 32'(cnt_clr), 32'd0);
    step(3);
    chk("t4_cnt3", 32'(cnt), 32'd3);
    chk("t4_inh3", 32'(cnt_inh), 32'd0);
    step(1);
    chk("t4_cnt4", 32'(cnt), 32'd4);
    chk("t4_inh4", 32'(cnt_inh), 32'd1);
    chk("t4_nodone_early", 32'(done), 32'd0);
    step(1);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_hold", 32'(cnt), 32'd4);
    req = 2'b00;
    step(1);
    chk("t4_grant_fall", 32'(grant), 32'd0);
    chk("t4_done_fall", 32'(done), 32'd0);
    chk("t4_hold2", 32'(cnt), 32'd4);

    // Target 0 on requester 1
    req = 2'b10; target1 = 10'd0;
    step(1);
    chk("t0_grant", 32'(grant), 32'h2);
    chk("t0_clr", 32'(cnt_clr), 32'd1);
    step(1);
    chk("t0_cnt", 32'(cnt), 32'd0);
    chk("t0_inh", 32'(cnt_inh), 32'd1);
    chk("t0_nodone", 32'(done), 32'd0);
    step(1);
    chk("t0_done", 32'(done), 32'h2);
    chk("t0_cnt_hold", 32'(cnt), 32'd0);
    req = 2'b00;
    step(1);
    chk("t0_idle", 32'(grant), 32'd0);

    // Abort at count 3; pointer must not rotate
    req = 2'b01; target0 = 10'd10;
    step(1);
    chk("ab_grant", 32'(grant), 32'h1);
    step(4);
    chk("ab_cnt3", 32'(cnt), 32'd3);
    req = 2'b00;
    step(1);
    chk("ab_grant_fall", 32'(grant), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_inh", 32'(cnt_inh), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    step(1);
    chk("ab_done2", 32'(done), 32'd0);
    req = 2'b11;
    step(1);
    chk("ab_ptr_grant", 32'(grant), 32'h1);
    req = 2'b00;
    step(2);
    chk("ab2_busy", 32'(busy), 32'd0);

    // Forced carry at count 2
    req = 2'b01; target0 = 10'd10;
    step(1);
    chk("cy_grant", 32'(grant), 32'h1);
    step(3);
    chk("cy_cnt2", 32'(cnt), 32'd2);
    carry_force = 1'b1;
    step(1);
    carry_force = 1'b0;
    chk("cy_err", 32'(err), 32'd1);
    chk("cy_done", 32'(done), 32'd0);
    chk("cy_grant_fall", 32'(grant), 32'd0);
    chk("cy_busy", 32'(busy), 32'd0);
    step(1);
    chk("cy_err_once", 32'(err), 32'd0);
    chk("cy_regrant", 32'(grant), 32'h1);
    req = 2'b00;
    step(3);
    chk("cy_settle", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN at count 3, then restart
    req = 2'b01; target0 = 10'd5;
    step(1);
    step(4);
    chk("mr_cnt3", 32'(cnt), 32'd3);
    chk("mr_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mr");
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1);
    chk("mr_restart_grant", 32'(grant), 32'h1);
    chk("mr_restart_clr", 32'(cnt_clr), 32'd1);
    step(1);
    chk("mr_restart_cnt0", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
